cpu_axi_bridge: RTL and testbench

- Sits directly downstream of the core top. Consumes the core's instruction-fetch port (inst_addr/inst_ena/inst_ready) and data port (data_addr/wmask/data_o/we/re).
- Arbitrates both ports onto one AXI4-Lite master. Returns fetched instructions with a valid strobe and load data with a mem_finish strobe.
- One outstanding transaction at a time. No caching, no bursts.

---
 rtl/cpu_axi_bridge.sv | 183 ++++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's fetch and load/store ports onto one AXI4-Lite master.
// Only one transaction is outstanding at a time, and data requests win arbitration over fetches.
module cpu_axi_bridge #(
  parameter int ADDR_W     = 64,
  parameter int AXI_ADDR_W = 32,
  parameter int DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_ena,
  input  logic [ADDR_W-1:0]     inst_addr,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [7:0]            wmask,
  input  logic [DATA_W-1:0]     data_o,
  output logic [DATA_W-1:0]     data_i,
  output logic                  mem_finish,
  output logic                  bus_err,
  output logic [AXI_ADDR_W-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [AXI_ADDR_W-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [7:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {IDLE, I_AR, I_R, I_HOLD, D_AR, D_R, D_WR, D_B} state_t;

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [7:0]            wstrb_q, wstrb_d;
  logic [DATA_W-1:0]     data_i_q, data_i_d;
  logic [31:0]           inst_q, inst_d;
  logic                  inst_valid_q, inst_valid_d;
  logic                  mem_finish_q, mem_finish_d;
  logic                  bus_err_q, bus_err_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  unused_ok;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both high. Valids are pure functions of state_q and per-channel done flags, so
  // once raised they hold, with the latched payload, until their ready is seen.
  assign m_arvalid = (state_q == I_AR) || (state_q == D_AR);
  assign m_araddr  = {addr_q[AXI_ADDR_W-1:3], 3'b000};
  assign m_arprot  = (state_q == I_AR) ? 3'b100 : 3'b000;
  assign m_rready  = (state_q == I_R) || (state_q == D_R);
  assign m_awvalid = (state_q == D_WR) && !aw_done_q;
  assign m_awaddr  = {addr_q[AXI_ADDR_W-1:3], 3'b000};
  assign m_awprot  = 3'b000;
  assign m_wvalid  = (state_q == D_WR) && !w_done_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_bready  = (state_q == D_B);

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign data_i     = data_i_q;
  assign mem_finish = mem_finish_q;
  assign bus_err    = bus_err_q;
  assign dbg_state  = state_q;

  assign unused_ok = ^{inst_addr[ADDR_W-1:AXI_ADDR_W], data_addr[ADDR_W-1:AXI_ADDR_W], addr_q[1:0]};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    data_i_d     = data_i_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    mem_finish_d = 1'b0;
    bus_err_d    = 1'b0;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    case (state_q)
      IDLE: begin
        // Only a fetch accepted together with inst_ready lands here with inst_valid set
        inst_valid_d = 1'b0;
        aw_done_d    = 1'b0;
        w_done_d     = 1'b0;
        if (re) begin
          addr_d  = data_addr[AXI_ADDR_W-1:0];
          state_d = D_AR;
        end else if (we) begin
          addr_d  = data_addr[AXI_ADDR_W-1:0];
          wdata_d = data_o;
          wstrb_d = wmask;
          state_d = D_WR;
        end else if (inst_ena && !inst_valid_q) begin
          addr_d  = inst_addr[AXI_ADDR_W-1:0];
          state_d = I_AR;
        end
      end
      I_AR: if (m_arready) state_d = I_R;
      I_R: begin
        if (m_rvalid) begin
          inst_d       = addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
          inst_valid_d = 1'b1;
          bus_err_d    = |m_rresp;
          state_d      = inst_ready ? IDLE : I_HOLD;
        end
      end
      I_HOLD: begin
        if (inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      D_AR: if (m_arready) state_d = D_R;
      D_R: begin
        if (m_rvalid) begin
          data_i_d     = m_rdata;
          mem_finish_d = 1'b1;
          bus_err_d    = |m_rresp;
          state_d      = IDLE;
        end
      end
      D_WR: begin
        aw_done_d = aw_done_q | m_awready;
        w_done_d  = w_done_q | m_wready;
        if (aw_done_d && w_done_d) state_d = D_B;
      end
      D_B: begin
        if (m_bvalid) begin
          mem_finish_d = 1'b1;
          bus_err_d    = |m_bresp;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      data_i_q     <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      mem_finish_q <= 1'b0;
      bus_err_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      data_i_q     <= data_i_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      mem_finish_q <= mem_finish_d;
      bus_err_q    <= bus_err_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: the bench plays the core and a hand-stepped AXI slave.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cpu_axi_bridge;
  localparam int ADDR_W     = 64;
  localparam int AXI_ADDR_W = 32;
  localparam int DATA_W     = 64;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_D_WR = 3'd6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  inst_ena, inst_ready, inst_valid;
  logic [ADDR_W-1:0]     inst_addr, data_addr;
  logic [31:0]           inst;
  logic                  re, we, mem_finish, bus_err;
  logic [7:0]            wmask, m_wstrb;
  logic [DATA_W-1:0]     data_o, data_i, m_rdata, m_wdata;
  logic [AXI_ADDR_W-1:0] m_araddr, m_awaddr;
  logic [2:0]            m_arprot, m_awprot, dbg_state;
  logic                  m_arvalid, m_arready, m_rvalid, m_rready;
  logic                  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]            m_rresp, m_bresp;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  cpu_axi_bridge #(.ADDR_W(ADDR_W), .AXI_ADDR_W(AXI_ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .inst_ena(inst_ena), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst(inst), .inst_valid(inst_valid),
    .re(re), .we(we), .data_addr(data_addr), .wmask(wmask), .data_o(data_o),
    .data_i(data_i), .mem_finish(mem_finish), .bus_err(bus_err),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .dbg_state(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Entered on the cycle AR should be up; leaves on the cycle the result is visible.
  task automatic slave_read(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                            input logic [63:0] rdata, input logic [1:0] resp);
    check_eq({tag, "_arvalid"}, m_arvalid, 1);
    check_eq({tag, "_araddr"}, m_araddr, addr);
    check_eq({tag, "_arprot"}, m_arprot, prot);
    m_arready = 1'b1;
    tick;
    m_arready = 1'b0;
    check_eq({tag, "_rready"}, m_rready, 1);
    check_eq({tag, "_ar_drop"}, m_arvalid, 0);
    m_rvalid = 1'b1;
    m_rdata  = rdata;
    m_rresp  = resp;
    tick;
    m_rvalid = 1'b0;
    m_rresp  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    inst_ena = 0; inst_ready = 0; inst_addr = '0;
    re = 0; we = 0; data_addr = '0; wmask = '0; data_o = '0;
    m_arready = 0; m_rdata = '0; m_rresp = 0; m_rvalid = 0;
    m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
    repeat (3) tick;
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_mem_finish", mem_finish, 0);
    check_eq("rst_bus_err", bus_err, 0);
    check_eq("rst_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
    check_eq("rst_inst", inst, 0);
    check_eq("rst_data_i", data_i, 0);
    check_eq("rst_state", dbg_state, S_IDLE);
    rst = 1'b0;

    // Fetch from upper word, zero-wait slave, core ready: one-cycle pulse
    inst_addr = 64'h8000_0004; inst_ena = 1; inst_ready = 1;
    exp_q.push_back(64'h0010_0093);
    tick;
    slave_read("fetch", 32'h8000_0000, 3'b100, 64'h00100093_00000013, 2'b00);
    check_eq("fetch_valid", inst_valid, 1);
    check_eq("fetch_inst", inst, exp_q.pop_front());
    check_eq("fetch_bus_err", bus_err, 0);
    inst_ena = 0;
    tick;
    check_eq("fetch_pulse", inst_valid, 0);
    check_eq("fetch_idle", dbg_state, S_IDLE);

    // Simultaneous fetch and load: load first, then fetch
    inst_addr = 64'h8000_0010; inst_ena = 1; re = 1; data_addr = 64'h8000_1000;
    exp_q.push_back(64'hDEADBEEF_CAFEF00D);
    tick;
    slave_read("arb_ld", 32'h8000_1000, 3'b000, 64'hDEADBEEF_CAFEF00D, 2'b00);
    check_eq("arb_ld_finish", mem_finish, 1);
    check_eq("arb_ld_data", data_i, exp_q.pop_front());
    check_eq("arb_no_inst", inst_valid, 0);
    re = 0;
    tick;
    check_eq("arb_finish_pulse", mem_finish, 0);
    exp_q.push_back(64'h2222_2222);
    slave_read("arb_if", 32'h8000_0010, 3'b100, 64'h11111111_22222222, 2'b00);
    check_eq("arb_if_valid", inst_valid, 1);
    check_eq("arb_if_inst", inst, exp_q.pop_front());
    inst_ena = 0;
    tick;

    // Store with AW accepted two cycles before W
    we = 1; data_addr = 64'h8000_2008; wmask = 8'h0F; data_o = 64'h11223344_55667788;
    tick;
    check_eq("st_aw_w_up", {m_awvalid, m_wvalid}, 2'b11);
    check_eq("st_awaddr", m_awaddr, 32'h8000_2008);
    check_eq("st_awprot", m_awprot, 0);
    check_eq("st_wdata", m_wdata, 64'h11223344_55667788);
    check_eq("st_wstrb", m_wstrb, 8'h0F);
    m_awready = 1;
    tick;
    m_awready = 0;
    check_eq("st_aw_drop", {m_awvalid, m_wvalid}, 2'b01);
    tick;
    check_eq("st_w_hold", {m_awvalid, m_wvalid, m_bready}, 3'b010);
    check_eq("st_wdata_hold", m_wdata, 64'h11223344_55667788);
    m_wready = 1;
    tick;
    m_wready = 0;
    check_eq("st_w_drop", {m_awvalid, m_wvalid}, 2'b00);
    check_eq("st_bready", m_bready, 1);
    check_eq("st_no_early_finish", mem_finish, 0);
    m_bvalid = 1;
    tick;
    m_bvalid = 0;
    check_eq("st_finish", mem_finish, 1);
    check_eq("st_bus_err", bus_err, 0);
    we = 0;
    tick;
    check_eq("st_finish_pulse", mem_finish, 0);
    check_eq("st_idle", dbg_state, S_IDLE);

    // Back-pressure on the fetch result, lower word of the AXI beat is skipped
    inst_addr = 64'h8000_0104; inst_ena = 1; inst_ready = 0;
    tick;
    slave_read("bp", 32'h8000_0100, 3'b100, 64'hAAAAAAAA_BBBBBBBB, 2'b00);
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_valid_hold", inst_valid, 1);
      check_eq("bp_inst_hold", inst, 64'hAAAA_AAAA);
      check_eq("bp_no_new_ar", m_arvalid, 0);
      if (i < 3) tick;
    end
    inst_ready = 1; inst_ena = 0;
    tick;
    check_eq("bp_valid_drop", inst_valid, 0);
    check_eq("bp_idle", dbg_state, S_IDLE);

    // Load with SLVERR: data still delivered, bus_err alongside mem_finish
    re = 1; data_addr = 64'h8000_3010;
    tick;
    slave_read("err", 32'h8000_3010, 3'b000, 64'h01234567_89ABCDEF, 2'b10);
    check_eq("err_finish", mem_finish, 1);
    check_eq("err_bus_err", bus_err, 1);
    check_eq("err_data", data_i, 64'h01234567_89ABCDEF);
    re = 0;
    tick;
    check_eq("err_pulses_drop", {mem_finish, bus_err}, 2'b00);
    check_eq("err_data_held", data_i, 64'h01234567_89ABCDEF);

    // Reset while a store is waiting on AW, then a clean fetch
    we = 1; data_addr = 64'h8000_4000; wmask = 8'hFF; data_o = 64'h5555_5555_5555_5555;
    tick;
    check_eq("rm_awvalid", m_awvalid, 1);
    check_eq("rm_state_wr", dbg_state, S_D_WR);
    rst = 1;
    tick;
    check_eq("rm_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
    check_eq("rm_state", dbg_state, S_IDLE);
    check_eq("rm_inst", inst, 0);
    check_eq("rm_data_i", data_i, 0);
    rst = 0; we = 0;
    inst_addr = 64'h8000_0008; inst_ena = 1; inst_ready = 1;
    tick;
    slave_read("rm_if", 32'h8000_0008, 3'b100, 64'h33333333_44444444, 2'b00);
    check_eq("rm_if_valid", inst_valid, 1);
    check_eq("rm_if_inst", inst, 64'h4444_4444);
    inst_ena = 0;
    tick;
    check_eq("rm_if_pulse", inst_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
